// File: rtl/n_input_gate_sweep_if.sv
// Bundle of the gate/sweep block's data and status signals.
//   master: drives mode, a, start; observes the outputs (board logic / bench)
//   slave : the n_input_gate_sweep block itself
//   mode       function select (AND/OR/NAND/NOR/XOR/XNOR)
//   a          manual input vector
//   start      sweep request, honoured only when idle
//   sweep_in   operand register currently applied to the gate
//   y          registered gate output
//   sample_stb last dwell cycle of a combination
//   busy       sweep in progress
//   done       one-cycle end-of-sweep pulse
//   ones_cnt   combinations that produced y=1 in the current/last sweep
interface n_input_gate_sweep_if #(
    parameter int unsigned N = 3
);
    logic [2:0]   mode;
    logic [N-1:0] a;
    logic         start;
    logic [N-1:0] sweep_in;
    logic         y;
    logic         sample_stb;
    logic         busy;
    logic         done;
    logic [N:0]   ones_cnt;

    modport master (
        output mode, a, start,
        input  sweep_in, y, sample_stb, busy, done, ones_cnt
    );

    modport slave (
        input  mode, a, start,
        output sweep_in, y, sample_stb, busy, done, ones_cnt
    );
endinterface

// File: rtl/n_input_gate_sweep.sv
// N-input logic gate with selectable function and a truth-table sweep engine.
// Manual mode registers a into sweep_in and the selected reduction into y.
// A start pulse in IDLE steps sweep_in through 0..2^N-1, holding each value
// for DWELL cycles, and counts the combinations for which y=1.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of n_input_gate_sweep_if (mode/a/start in; status out)
module n_input_gate_sweep #(
    parameter int unsigned N     = 3,
    parameter int unsigned DWELL = 100
) (
    input logic                clk,
    input logic                rst,
    n_input_gate_sweep_if.slave bus
);
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned CW = N + 1;
    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e         state_q, state_d;
    logic [2:0]     mode_q, mode_d;
    logic [N-1:0]   sweep_in_q, sweep_in_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [CW-1:0]  ones_cnt_q, ones_cnt_d;
    logic           y_q, y_d;
    logic           sample_stb;

    // Full reduction over sweep_in using the frozen/registered function.
    always_comb begin
        y_d = &sweep_in_q;
        case (mode_q)
            3'b001:  y_d = |sweep_in_q;
            3'b010:  y_d = ~&sweep_in_q;
            3'b011:  y_d = ~|sweep_in_q;
            3'b100:  y_d = ^sweep_in_q;
            3'b101:  y_d = ~^sweep_in_q;
            default: y_d = &sweep_in_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sweep_in_d = sweep_in_q;
        dwell_d    = dwell_q;
        ones_cnt_d = ones_cnt_q;
        sample_stb = 1'b0;
        case (state_q)
            StIdle: begin
                mode_d = bus.mode;
                if (bus.start) begin
                    state_d    = StSweep;
                    sweep_in_d = '0;
                    dwell_d    = '0;
                    ones_cnt_d = '0;
                end else begin
                    sweep_in_d = bus.a;
                end
            end
            StSweep: begin
                dwell_d = dwell_q + 1'b1;
                if (dwell_q == DwellLast) begin
                    sample_stb = 1'b1;
                    // y has settled on the current operand since dwell 1.
                    if (y_q) begin
                        ones_cnt_d = ones_cnt_q + 1'b1;
                    end
                    dwell_d = '0;
                    if (&sweep_in_q) begin
                        state_d = StDone;
                    end else begin
                        sweep_in_d = sweep_in_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= 3'b000;
            sweep_in_q <= '0;
            dwell_q    <= '0;
            ones_cnt_q <= '0;
            y_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sweep_in_q <= sweep_in_d;
            dwell_q    <= dwell_d;
            ones_cnt_q <= ones_cnt_d;
            y_q        <= y_d;
        end
    end

    assign bus.sweep_in   = sweep_in_q;
    assign bus.y          = y_q;
    assign bus.sample_stb = sample_stb;
    assign bus.busy       = (state_q == StSweep);
    assign bus.done       = (state_q == StDone);
    assign bus.ones_cnt   = ones_cnt_q;
endmodule
